// File: rtl/usb_rx_deser_if.sv
// Bundles the USB receive deserializer's line inputs and word outputs.
// master: the side that drives the sampled line and consumes the words.
// slave : the deserializer itself.
// Handshake: bit_valid is a one-cycle strobe with no back-pressure. dp/se0 are
// meaningful only while it is high. word_valid is a one-cycle strobe with no ready.
// word/word_bytes/word_last are qualified by word_valid and hold until the next
// emission. dbg_state mirrors the FSM state (0=IDLE 1=SYNC 2=DATA 3=ERR).
interface usb_rx_deser_if #(
    parameter int WIDTH = 32
);
    logic             bit_valid;
    logic             dp;
    logic             se0;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic [2:0]       word_bytes;
    logic             word_last;
    logic             pkt_active;
    logic             err_stuff;
    logic             err_align;
    logic [1:0]       dbg_state;

    modport master (
        output bit_valid, dp, se0,
        input  word, word_valid, word_bytes, word_last,
        input  pkt_active, err_stuff, err_align, dbg_state
    );

    modport slave (
        input  bit_valid, dp, se0,
        output word, word_valid, word_bytes, word_last,
        output pkt_active, err_stuff, err_align, dbg_state
    );
endinterface

// File: rtl/usb_rx_deser.sv
// USB receive deserializer: NRZI decode, SYNC detection, bit unstuffing and
// LSB-first assembly of payload bits into WIDTH-bit words. It flags the
// end of a packet, stuffing violations and EOPs that are not byte-aligned.
module usb_rx_deser #(
    parameter int WIDTH     = 32,
    parameter int STUFF_LEN = 6,
    parameter int SYNC_MIN  = 5
) (
    input  logic           clk,
    input  logic           reset,
    usb_rx_deser_if.slave  io_bus
);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] STUFF_CNT  = ONES_W'(STUFF_LEN);
    localparam logic [2:0]        SYNC_CNT   = 3'(SYNC_MIN);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [2:0]        FULL_BYTES = 3'(WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_prev_dp;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [ONES_W-1:0] r_ones_cnt;
    logic [2:0]        r_zero_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_word;
    logic              r_word_valid;
    logic [2:0]        r_word_bytes;
    logic              r_word_last;
    logic              r_err_stuff;
    logic              r_err_align;

    // A decoded 1 is "no transition" relative to the previous sampled level.
    logic w_bit;
    logic w_aligned;
    assign w_bit     = (io_bus.dp == r_prev_dp);
    assign w_aligned = (r_bit_idx[2:0] == 3'd0);

    // Main FSM: line decode, sync hunt, unstuffing, word assembly and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prev_dp    <= 1'b1;
            r_bit_idx    <= '0;
            r_ones_cnt   <= '0;
            r_zero_cnt   <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_word_bytes <= '0;
            r_word_last  <= 1'b0;
            r_err_stuff  <= 1'b0;
            r_err_align  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_err_stuff  <= 1'b0;
            r_err_align  <= 1'b0;
            if (io_bus.bit_valid) begin
                // After SE0 the line returns to J, so the next bit is judged against J.
                r_prev_dp <= io_bus.se0 ? 1'b1 : io_bus.dp;
                case (r_state)
                    S_IDLE: begin
                        if (!io_bus.se0 && !w_bit) begin
                            r_state    <= S_SYNC;
                            r_zero_cnt <= 3'd1;
                        end
                    end
                    S_SYNC: begin
                        if (io_bus.se0) begin
                            r_state <= S_IDLE;
                        end else if (!w_bit) begin
                            if (r_zero_cnt != 3'd7) r_zero_cnt <= r_zero_cnt + 3'd1;
                        end else if (r_zero_cnt >= SYNC_CNT) begin
                            // The SYNC-terminating 1 counts toward the stuffing run.
                            r_state    <= S_DATA;
                            r_bit_idx  <= '0;
                            r_ones_cnt <= ONES_W'(1);
                            r_acc      <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        if (io_bus.se0) begin
                            r_state   <= S_IDLE;
                            r_acc     <= '0;
                            r_bit_idx <= '0;
                            if (w_aligned) begin
                                // Unwritten upper bytes of acc are already zero.
                                if (r_bit_idx != '0) r_word <= r_acc;
                                r_word_valid <= 1'b1;
                                r_word_bytes <= 3'(r_bit_idx >> 3);
                                r_word_last  <= 1'b1;
                            end else begin
                                r_err_align <= 1'b1;
                            end
                        end else if (r_ones_cnt == STUFF_CNT) begin
                            if (w_bit) begin
                                r_err_stuff <= 1'b1;
                                r_state     <= S_ERR;
                                r_acc       <= '0;
                            end else begin
                                r_ones_cnt <= '0;
                            end
                        end else begin
                            r_acc[r_bit_idx] <= w_bit;
                            r_ones_cnt       <= w_bit ? r_ones_cnt + 1'b1 : '0;
                            r_bit_idx        <= r_bit_idx + 1'b1;
                            if (r_bit_idx == LAST_IDX) begin
                                r_word       <= {w_bit, r_acc[WIDTH-2:0]};
                                r_word_valid <= 1'b1;
                                r_word_bytes <= FULL_BYTES;
                                r_word_last  <= 1'b0;
                                r_acc        <= '0;
                            end
                        end
                    end
                    S_ERR: begin
                        if (io_bus.se0) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign io_bus.word       = r_word;
    assign io_bus.word_valid = r_word_valid;
    assign io_bus.word_bytes = r_word_bytes;
    assign io_bus.word_last  = r_word_last;
    assign io_bus.err_stuff  = r_err_stuff;
    assign io_bus.err_align  = r_err_align;
    assign io_bus.pkt_active = (r_state == S_DATA) || (r_state == S_ERR);
    assign io_bus.dbg_state  = r_state;
endmodule
